// File: rtl/apb_pkg.sv
// Types and bus widths shared by the APB side of the AHB-to-APB bridge
// and its completers.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_t;
endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode for the APB register file.
// Turns a byte address into a register index plus the error/read-only flags.
module apb_addr_decode #(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    localparam int               IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] paddr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              err_misalign_o,
    output logic              err_range_o,
    output logic              is_ro_o
);
    logic [ADDR_W-1:0] offset_s;

    // Addresses below the base wrap to a huge offset and fall out of range.
    always_comb begin
        offset_s       = paddr_i - BASE_ADDR;
        idx_o          = offset_s[IDX_W+1:2];
        err_misalign_o = (paddr_i[1:0] != 2'b00);
        err_range_o    = |(offset_s >> (IDX_W + 2));
        is_ro_o        = (idx_o == {IDX_W{1'b0}});
    end
endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer with a word-addressed register file, programmable wait
// states and pslverr on misaligned, out-of-range or read-only accesses.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [IDX_W-1:0]  dec_idx_s;
    logic              dec_misalign_s;
    logic              dec_range_s;
    logic              dec_ro_s;
    logic              we_s;
    logic [DATA_W-1:0] rdata_s;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .paddr_i        (paddr),
        .idx_o          (dec_idx_s),
        .err_misalign_o (dec_misalign_s),
        .err_range_o    (dec_range_s),
        .is_ro_o        (dec_ro_s)
    );

    // Control state register: FSM, wait counter and setup-phase captures.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= APB_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; a write commits only on the completing edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        we_s    = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (psel && !penable) begin
                    state_d = APB_ACCESS;
                    cnt_d   = WAIT_INIT;
                    write_d = pwrite;
                    idx_d   = dec_idx_s;
                    err_d   = dec_misalign_s | dec_range_s | (pwrite & dec_ro_s);
                end else begin
                    state_d = APB_IDLE;
                end
            end
            APB_ACCESS: begin
                if (!psel) begin
                    state_d = APB_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (penable) begin
                    state_d = APB_IDLE;
                    we_s    = write_q & ~err_q;
                end else begin
                    state_d = APB_ACCESS;
                end
            end
            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // Register array; entry 0 is never written and reads return ID_VALUE.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            regs_q[idx_q] <= pwdata;
        end
    end

    // Response outputs, forced quiet while reset is held.
    always_comb begin
        rdata_s = (idx_q == {IDX_W{1'b0}}) ? ID_VALUE : regs_q[idx_q];
        pready  = (state_q == APB_ACCESS) && (cnt_q == 4'd0) && !hreset;
        pslverr = pready & err_q;
        if (pready && !write_q && !err_q) begin
            prdata = rdata_s;
        end else begin
            prdata = {DATA_W{1'b0}};
        end
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed self-checking bench for apb_regfile_slave (WAIT_STATES=1, 16 regs).
module tb_apb_regfile_slave;
    logic        hclk;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    localparam logic [31:0] ID = 32'hA2B0_0001;

    int n_checks = 0;
    int n_fail   = 0;

    apb_regfile_slave #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_REGS    (16),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (1),
        .ID_VALUE    (32'hA2B0_0001)
    ) dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete APB transfer; returns sampled response and total cycle count.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cycles);
        bit done;
        done   = 1'b0;
        rdata  = 32'h0;
        err    = 1'b0;
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge hclk); #1;
        penable = 1'b1;
        cycles  = 1;
        for (int k = 0; k < 20; k++) begin
            cycles++;
            @(negedge hclk);
            if (pready) begin
                rdata = prdata;
                err   = pslverr;
                done  = 1'b1;
            end
            @(posedge hclk); #1;
            if (done) break;
        end
        psel = 1'b0; penable = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no pready for addr %h", addr);
        end
    endtask

    vec_t        vecs[14];
    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0;

        vecs[0]  = '{1'b0, 32'h00, 32'h0,         ID,            1'b0};
        vecs[1]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h00, 32'h0000_1234, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h00, 32'h0,         ID,            1'b0};
        vecs[5]  = '{1'b0, 32'h41, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h40, 32'h0000_FFFF, 32'h0,         1'b1};
        vecs[8]  = '{1'b1, 32'h3C, 32'h0BAD_F00D, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h3C, 32'h0,         32'h0BAD_F00D, 1'b0};
        vecs[10] = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b1, 32'h0A, 32'h0000_0077, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0};

        // Outputs quiet while reset is held.
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("reset_pready",  {31'h0, pready},  32'h0);
        chk("reset_pslverr", {31'h0, pslverr}, 32'h0);
        chk("reset_prdata",  prdata,           32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("idle_pready", {31'h0, pready}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, cyc);
            chk($sformatf("vec%0d_prdata", i),  rd,             vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), {31'h0, er},    {31'h0, vecs[i].exp_err});
            chk($sformatf("vec%0d_cycles", i),  32'(cyc),       32'd3);
        end

        // Abort: psel drops during the wait cycle of a write to 0x4.
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55;
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge hclk);
        chk("abort_wait_pready", {31'h0, pready}, 32'h0);
        @(negedge hclk);
        chk("abort_after_pready", {31'h0, pready}, 32'h0);
        @(negedge hclk);
        chk("abort_idle_pready", {31'h0, pready}, 32'h0);
        apb_xfer(1'b0, 32'h04, 32'h0, rd, er, cyc);
        chk("abort_read4", rd, 32'h0);

        // Load some registers, then reset in the middle of a write to 0xC.
        apb_xfer(1'b1, 32'h04, 32'h0000_0011, rd, er, cyc);
        apb_xfer(1'b1, 32'h0C, 32'h0000_0033, rd, er, cyc);
        apb_xfer(1'b0, 32'h0C, 32'h0, rd, er, cyc);
        chk("preload_read_c", rd, 32'h0000_0033);
        @(posedge hclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h99;
        @(posedge hclk); #1;
        penable = 1'b1; hreset = 1'b1;
        @(negedge hclk);
        chk("midreset_pready", {31'h0, pready}, 32'h0);
        chk("midreset_prdata", prdata,          32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge hclk);
        chk("postreset_pready", {31'h0, pready}, 32'h0);
        for (int r = 0; r < 16; r++) begin
            apb_xfer(1'b0, 32'(r * 4), 32'h0, rd, er, cyc);
            chk($sformatf("postreset_reg%0d", r), rd, (r == 0) ? ID : 32'h0);
            chk($sformatf("postreset_err%0d", r), {31'h0, er}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
